// File: rtl/pipe_hazard_unit_if.sv
// Interface bundling the OF-stage decode inputs, branch/freeze controls and
// the hazard unit's stall, flush, forwarding and statistics outputs.
interface pipe_hazard_unit_if #(
   parameter int REG_AW  = 4,
   parameter int NUM_SRC = 2,
   parameter int CNT_W   = 16
);

   logic                        of_valid;
   logic [NUM_SRC*REG_AW-1:0]   of_src;
   logic [NUM_SRC-1:0]          of_src_used;
   logic [REG_AW-1:0]           of_dst;
   logic                        of_is_wb;
   logic                        of_is_ld;
   logic                        ex_branch_taken;
   logic                        ext_stall;

   logic                        stall_if;
   logic                        bubble_of_ex;
   logic                        flush_if_of;
   logic [NUM_SRC*2-1:0]        fwd_sel;
   logic [CNT_W-1:0]            stall_count;
   logic [CNT_W-1:0]            flush_count;

   // Pipeline side: supplies decode info and controls, observes hazard results
   modport master (
      output of_valid, of_src, of_src_used, of_dst, of_is_wb, of_is_ld,
      output ex_branch_taken, ext_stall,
      input  stall_if, bubble_of_ex, flush_if_of, fwd_sel,
      input  stall_count, flush_count
   );

   // Hazard unit side
   modport slave (
      input  of_valid, of_src, of_src_used, of_dst, of_is_wb, of_is_ld,
      input  ex_branch_taken, ext_stall,
      output stall_if, bubble_of_ex, flush_if_of, fwd_sel,
      output stall_count, flush_count
   );

endinterface

// File: rtl/pipe_hazard_unit.sv
// Interlock and forwarding controller for the 5-stage SimpleRisc pipeline.
// Keeps a shadow scoreboard of the EX/MA/RW destinations, raises load-use
// stalls and branch flushes, and registers per-source forwarding selects.
module pipe_hazard_unit #(
   parameter int REG_AW  = 4,
   parameter int NUM_SRC = 2,
   parameter int CNT_W   = 16
) (
   input logic             clk,
   input logic             reset,
   pipe_hazard_unit_if.slave hz
);

   // Operand source codes for the EX-stage muxes; the producer has moved one
   // stage further by the time the consumer reaches EX.
   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_MA  = 2'd1,
      FWD_RW  = 2'd2,
      FWD_LWB = 2'd3
   } fwd_sel_e;

   typedef struct packed {
      logic              valid;
      logic              wb;
      logic [REG_AW-1:0] dst;
      logic              is_ld;
   } sb_entry_t;

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   sb_entry_t               ex_e;
   sb_entry_t               ma_e;
   sb_entry_t               rw_e;
   logic [NUM_SRC*2-1:0]    fwd_q;
   logic [CNT_W-1:0]        stall_cnt;
   logic [CNT_W-1:0]        flush_cnt;

   logic [NUM_SRC*2-1:0]    sel_next;
   logic                    load_use;
   logic                    flush;
   logic                    stall;
   logic                    unused_rw_ld;

   // The oldest slot's load flag has no consumer; it is kept so every slot
   // carries the same record.
   assign unused_rw_ld = rw_e.is_ld;

   // Match each used source against the scoreboard, youngest producer first,
   // and flag a load-use hazard when the matching EX producer is a load.
   always_comb begin
      logic [REG_AW-1:0] src;
      logic              rd;
      logic              hit_ex;
      logic              hit_ma;
      logic              hit_rw;
      sel_next = '0;
      load_use = 1'b0;
      src      = '0;
      rd       = 1'b0;
      hit_ex   = 1'b0;
      hit_ma   = 1'b0;
      hit_rw   = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         src    = hz.of_src[i*REG_AW +: REG_AW];
         rd     = hz.of_valid && hz.of_src_used[i];
         hit_ex = rd && ex_e.valid && ex_e.wb && (ex_e.dst == src);
         hit_ma = rd && ma_e.valid && ma_e.wb && (ma_e.dst == src);
         hit_rw = rd && rw_e.valid && rw_e.wb && (rw_e.dst == src);
         if (hit_ex) begin
            if (ex_e.is_ld) begin
               load_use = 1'b1;
            end else begin
               sel_next[2*i +: 2] = FWD_MA;
            end
         end else if (hit_ma) begin
            sel_next[2*i +: 2] = FWD_RW;
         end else if (hit_rw) begin
            sel_next[2*i +: 2] = FWD_LWB;
         end
      end
   end

   // A taken branch wins over a load-use stall, and a global freeze masks both.
   // While reset is held every control output is forced low.
   always_comb begin
      flush           = hz.ex_branch_taken && !hz.ext_stall;
      stall           = load_use && !flush && !hz.ext_stall;
      hz.stall_if     = !reset && (hz.ext_stall || stall);
      hz.bubble_of_ex = !reset && !hz.ext_stall && (flush || load_use);
      hz.flush_if_of  = !reset && flush;
   end

   // Advance the scoreboard on every unfrozen edge; a stall or flush puts a
   // bubble into EX and clears the select registered for it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_e  <= '0;
         ma_e  <= '0;
         rw_e  <= '0;
         fwd_q <= '0;
      end else if (!hz.ext_stall) begin
         rw_e <= ma_e;
         ma_e <= ex_e;
         if (stall || flush) begin
            ex_e  <= '0;
            fwd_q <= '0;
         end else begin
            ex_e.valid <= hz.of_valid;
            ex_e.wb    <= hz.of_is_wb;
            ex_e.dst   <= hz.of_dst;
            ex_e.is_ld <= hz.of_is_ld;
            fwd_q      <= sel_next;
         end
      end
   end

   // Saturating statistics: load-use stall cycles and taken-branch flushes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (!hz.ext_stall) begin
         if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end
         if (flush && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CNT_ONE;
         end
      end
   end

   assign hz.fwd_sel     = fwd_q;
   assign hz.stall_count = stall_cnt;
   assign hz.flush_count = flush_cnt;

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised interlock and forwarding controller for the SimpleRisc 5-stage pipeline (IF, OF, EX, MA, RW). Branches are predict-not-taken with no delay slots.
- Tracks the destination registers of in-flight instructions in a shadow scoreboard (EX, MA and RW slots).
- Issues load-use stalls, bubble insertion and branch flushes, and produces per-source registered forwarding selects for the EX-stage operand muxes.
- Sits beside the IF/OF and OF/EX latches. Consumes decode outputs of the control unit in OF.

Parameters:
- REG_AW, 4, register-address width (16 architectural registers).
- NUM_SRC, 2, number of tracked source operands per instruction, 2..3 (3 covers st's rd read).
- CNT_W, 16, width of the stall and flush statistics counters.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- of_valid  in  1  OF stage holds a real instruction.
- of_src  in  NUM_SRC*REG_AW  source register addresses, packed, source 0 in LSBs.
- of_src_used  in  NUM_SRC  per-source "operand actually read" flag.
- of_dst  in  REG_AW  destination register (ra=15 for call, decoded upstream).
- of_is_wb  in  1  OF instruction writes the register file.
- of_is_ld  in  1  OF instruction is ld.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- ext_stall  in  1  global freeze (memory busy).
- stall_if  out  1  hold PC and IF/OF latch (combinational).
- bubble_of_ex  out  1  load NOP into OF/EX latch (combinational).
- flush_if_of  out  1  squash IF/OF latch (combinational).
- fwd_sel  out  NUM_SRC*2  registered per-source select for the EX operand: 0 regfile, 1 MA result, 2 RW result, 3 retained last-writeback register.
- stall_count  out  CNT_W  saturating count of load-use stall cycles.
- flush_count  out  CNT_W  saturating count of taken-branch flushes.

Behaviour:
- Scoreboard: 3 entries {valid, wb, dst, is_ld} for EX, MA and RW. Reset makes all entries invalid, fwd_sel=0 and both counters 0.
- Reset is asynchronous. Asserting it mid-operation clears state immediately; combinational outputs then go to 0.
- Hazard match for source i: of_valid, of_src_used[i], entry valid and wb, and entry dst == src_i.
- Load-use:
  - Condition: a match against the EX entry with is_ld=1.
  - Response: stall_if=1 and bubble_of_ex=1 for exactly one cycle. The EX entry becomes a bubble, and the OF instruction is re-evaluated next cycle (the load is then in MA).
  - Only the load in EX triggers a stall; all other RAW hazards are resolved by forwarding, never by stall.
- Forward select, computed in OF and registered into fwd_sel when the instruction advances to EX:
  - Match EX entry (non-load) -> 1.
  - Else match MA entry -> 2.
  - Else match RW entry -> 3.
  - Else 0.
  - Youngest producer wins when several match.
  - Unused sources -> 0. Bubble or flushed advance -> all fwd_sel=0.
- Advance: on each non-frozen edge, MA->RW and EX->MA. EX loads {of_valid, of_is_wb, of_dst, of_is_ld}, or a bubble if stalled or flushed.
- Flush (ex_branch_taken=1, ext_stall=0):
  - flush_if_of=1 and bubble_of_ex=1; stall_if forced 0. Flush overrides load-use.
  - The EX entry next cycle is a bubble and flush_count increments.
  - The taken branch itself advances to MA normally.
- ext_stall=1:
  - Scoreboard, fwd_sel and counters hold.
  - stall_if=1; bubble_of_ex=0 and flush_if_of=0.
  - ex_branch_taken is ignored and resampled once the freeze drops.
- stall_count increments on each load-use stall cycle. Both counters saturate at all-ones.
- Registers are never hardwired to zero; r0 hazards are tracked like any other register.

Test Plan:
- Forward from MA: add r1 issued, then add r2,r1,r3 next cycle -> no stall; fwd_sel[1:0]=1 when the consumer is in EX.
- Distance-2 and distance-3 producers: r4 written, then one NOP, then a consumer of r4 -> fwd_sel=2. With two NOPs -> fwd_sel=3. With three NOPs -> 0.
- Load-use: ld r5,[r6] followed by sub r7,r5,r8 -> stall_if=1 and bubble_of_ex=1 for one cycle; consumer then gets fwd_sel=2; stall_count=1.
- Branch flush over load-use:
  - Setup: ex_branch_taken=1 in the same cycle a load-use hazard is detected.
  - Required: flush_if_of=1, bubble_of_ex=1, stall_if=0; flush_count=1; next EX entry invalid.
- Freeze: ext_stall=1 for 3 cycles during a pending forward -> fwd_sel, counters and scoreboard unchanged; after release the forward resolves as without the freeze.
- Mid-run reset: pulse reset between edges with MA holding wb r9 -> fwd_sel=0 immediately; a later consumer of r9 gets fwd_sel=0. Counter saturation: preload near 2^CNT_W-1 and check the counter holds at all-ones.
